// File: rtl/video_palframe_banked.sv
// video_palframe_banked: banked palette mixer with blanking, a CPU palette port served
// only during blank, and a display bank switch deferred to the vblank rising edge.
module video_palframe_banked #(
  parameter int IDX_W  = 4,
  parameter int COL_W  = 6,
  parameter int BANK_W = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hpix,
  input  logic                    vpix,
  input  logic                    hblank,
  input  logic                    vblank,
  input  logic [IDX_W-1:0]        pixels,
  input  logic [IDX_W-1:0]        border,
  input  logic [BANK_W-1:0]       bank_sel,
  input  logic                    pal_wr_req,
  input  logic                    pal_rd_req,
  input  logic [BANK_W+IDX_W-1:0] pal_addr,
  input  logic [COL_W-1:0]        pal_wdata,
  output logic                    pal_ack,
  output logic [COL_W-1:0]        pal_rdata,
  output logic                    pal_rvalid,
  output logic [BANK_W-1:0]       disp_bank,
  output logic [COL_W-1:0]        color
);
  localparam int AW = BANK_W + IDX_W;
  logic [COL_W-1:0] ram [(1<<AW)];
  logic [IDX_W-1:0] idx0;
  logic blk0, vb_q, vb_qq, rd_pend, svc;
  // the cycle right after an ack is never serviced, so a held request cannot be acked twice
  assign svc = blk0 & ~pal_ack & (pal_wr_req | pal_rd_req);
  always_ff @(posedge clk)
    if (svc & pal_wr_req) ram[pal_addr] <= pal_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx0       <= '0;
      blk0       <= 1'b1;
      vb_q       <= 1'b0;
      vb_qq      <= 1'b0;
      disp_bank  <= '0;
      color      <= '0;
      pal_ack    <= 1'b0;
      rd_pend    <= 1'b0;
      pal_rvalid <= 1'b0;
      pal_rdata  <= '0;
    end else begin
      idx0       <= (hpix & vpix) ? pixels : border;
      blk0       <= hblank | vblank;
      vb_q       <= vblank;
      vb_qq      <= vb_q;
      disp_bank  <= (vb_q & ~vb_qq) ? bank_sel : disp_bank;
      color      <= blk0 ? '0 : ram[{disp_bank, idx0}];
      pal_ack    <= svc;
      rd_pend    <= svc & ~pal_wr_req;
      pal_rvalid <= rd_pend;
      pal_rdata  <= (svc & ~pal_wr_req) ? ram[pal_addr] : pal_rdata;
    end
endmodule

// File: tb/tb_video_palframe_banked.sv
// tb_video_palframe_banked: directed stimulus with a per-cycle reference model of the palette mixer.
module tb_video_palframe_banked;
  localparam int IW = 4, CW = 6, BW = 1, AW = 5;
  logic clk = 0, rst_n = 0, hpix = 0, vpix = 0, hblank = 0, vblank = 1;
  logic [IW-1:0] pixels = '0, border = '0;
  logic [BW-1:0] bank_sel = '0;
  logic pal_wr_req = 0, pal_rd_req = 0;
  logic [AW-1:0] pal_addr = '0;
  logic [CW-1:0] pal_wdata = '0;
  logic pal_ack, pal_rvalid;
  logic [CW-1:0] pal_rdata, color;
  logic [BW-1:0] disp_bank;
  int total = 0, bad = 0, ackcnt;
  logic [CW-1:0] mram [32];
  bit mv [32];
  bit p_blk = 1, vb1 = 0, vb2 = 0, prev_ack = 0;
  logic [IW-1:0] p_idx = '0;
  logic [BW-1:0] mbank = '0;
  logic [AW-1:0] ma;

  always #5 clk = ~clk;

  video_palframe_banked #(.IDX_W(IW), .COL_W(CW), .BANK_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .hpix(hpix), .vpix(vpix), .hblank(hblank), .vblank(vblank),
    .pixels(pixels), .border(border), .bank_sel(bank_sel), .pal_wr_req(pal_wr_req),
    .pal_rd_req(pal_rd_req), .pal_addr(pal_addr), .pal_wdata(pal_wdata), .pal_ack(pal_ack),
    .pal_rdata(pal_rdata), .pal_rvalid(pal_rvalid), .disp_bank(disp_bank), .color(color)
  );

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // reference: colour is a lookup of the index/blank seen one edge earlier in the bank shown then
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      p_blk = 1; p_idx = '0; vb1 = 0; vb2 = 0; mbank = '0; prev_ack = 0;
    end else begin
      ma = {mbank, p_idx};
      if (p_blk) chk("model_color_blank", color, 0);
      else if (mv[ma]) chk("model_color", color, mram[ma]);
      if (vb1 && !vb2) mbank = bank_sel;
      chk("model_disp_bank", disp_bank, mbank);
      chk("ack_back_to_back", pal_ack & prev_ack, 0);
      prev_ack = pal_ack;
      vb2 = vb1; vb1 = vblank;
      p_blk = hblank | vblank;
      p_idx = (hpix & vpix) ? pixels : border;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #4; end
  endtask

  task automatic wait_ack(string n);
    int i = 0;
    do begin step(); i++; end while (!pal_ack && i < 200);
    chk(n, pal_ack, 1);
  endtask

  task automatic wr(logic [AW-1:0] a, logic [CW-1:0] d);
    pal_addr = a; pal_wdata = d; pal_wr_req = 1;
    wait_ack("wr_ack");
    step();
    chk("wr_single_ack", pal_ack, 0);
    pal_wr_req = 0; mram[a] = d; mv[a] = 1;
  endtask

  task automatic rd(logic [AW-1:0] a, logic [CW-1:0] e);
    pal_addr = a; pal_rd_req = 1;
    wait_ack("rd_ack");
    step();
    chk("rvalid", pal_rvalid, 1);
    chk("rdata", pal_rdata, e);
    pal_rd_req = 0;
    step();
    chk("rvalid_drop", pal_rvalid, 0);
    chk("rdata_hold", pal_rdata, e);
  endtask

  task automatic active();
    vblank = 0; hblank = 0; hpix = 1; vpix = 1;
  endtask

  initial begin
    step(3);
    chk("rst_color", color, 0);
    chk("rst_ack", pal_ack, 0);
    chk("rst_rvalid", pal_rvalid, 0);
    chk("rst_rdata", pal_rdata, 0);
    chk("rst_disp_bank", disp_bank, 0);
    rst_n = 1;
    step(2);
    wr(5'h05, 6'h2A);
    wr(5'h03, 6'h11);
    step(2);
    active(); pixels = 4'd5;
    step(); chk("lat_still_blank", color, 0);
    step(); chk("pixel_idx5", color, 6'h2A);
    hpix = 0; border = 4'd3;
    step(); chk("border_lat1", color, 6'h2A);
    step(); chk("border_idx3", color, 6'h11);
    hblank = 1;
    step(); chk("hpulse_lat1", color, 6'h11);
    hblank = 0;
    step(); chk("hpulse_black", color, 0);
    step(); chk("hpulse_back", color, 6'h11);
    pal_addr = 5'h07; pal_wdata = 6'h15; pal_wr_req = 1; ackcnt = 0;
    repeat (40) begin step(); ackcnt += int'(pal_ack); end
    chk("no_ack_active", ackcnt, 0);
    vblank = 1;
    wait_ack("stalled_wr_ack");
    step(); pal_wr_req = 0; mram[7] = 6'h15; mv[7] = 1;
    rd(5'h07, 6'h15);
    pal_addr = 5'h13; pal_wdata = 6'h3F; pal_wr_req = 1; pal_rd_req = 1;
    wait_ack("both_first_ack");
    step();
    chk("both_gap", pal_ack, 0);
    pal_wr_req = 0; mram[5'h13] = 6'h3F; mv[5'h13] = 1;
    step();
    chk("both_second_ack", pal_ack, 1);
    step();
    chk("both_rvalid", pal_rvalid, 1);
    chk("both_rdata", pal_rdata, 6'h3F);
    pal_rd_req = 0;
    wr(5'h15, 6'h07);
    active(); pixels = 4'd5;
    step(3); chk("bank0_pixel", color, 6'h2A);
    bank_sel = 1; step(2); bank_sel = 0; step(2); bank_sel = 1; step(3);
    chk("bank_hold_color", color, 6'h2A);
    chk("bank_hold_disp", disp_bank, 0);
    vblank = 1;
    step(4); chk("bank_switched", disp_bank, 1);
    active();
    step(2); chk("bank1_pixel", color, 6'h07);
    pal_addr = 5'h05; pal_rd_req = 1;
    step(3); chk("rd_stall_active", pal_ack, 0);
    #1 rst_n = 0; pal_rd_req = 0;
    #1;
    chk("midrst_color", color, 0);
    chk("midrst_ack", pal_ack, 0);
    chk("midrst_rvalid", pal_rvalid, 0);
    chk("midrst_disp_bank", disp_bank, 0);
    step(2);
    rst_n = 1;
    step(2);
    vblank = 1; bank_sel = 0;
    step(2);
    rd(5'h05, 6'h2A);
    active();
    step(3); chk("post_rst_pixel", color, 6'h2A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
